gpio_in_debounce: RTL
=====================

Name: gpio_in_debounce

Overview:
- Input conditioning stage between the board switch pins and the SoC GPIO input bus (gpio_bi switch field).
- Each bit passes through a multi-stage synchronizer, then a per-bit stability counter. The bit is forwarded only after it has held a new level for a programmable number of cycles.
- Also produces one-cycle rise/fall strobes and a sticky change flag, so firmware polling GPIO sees clean levels and cannot miss events.

Parameters:
- WIDTH, 16, number of independent input bits.
- SYNC_STAGES, 2, synchronizer flops per bit. Legal range is 2 or more; values below 2 are clamped to 2.
- DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronized level must differ from data_o before data_o takes it. Legal range is 1 or more.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into the synchronizer flops and data_o at reset.
- Local parameter CNT_W = $clog2(DEBOUNCE_CYCLES+1), the per-bit counter width.

Ports:
- clk_i  in  1  system clock, PLL output domain.
- arst_n_i  in  1  reset, asynchronous assert, active-low.
- raw_i  in  WIDTH  asynchronous raw pin inputs (switches).
- data_o  out  WIDTH  debounced stable levels, fed to the GPIO input bus.
- rise_o  out  WIDTH  one-cycle strobe per bit on a debounced 0->1 transition.
- fall_o  out  WIDTH  one-cycle strobe per bit on a debounced 1->0 transition.
- chg_o  out  1  one-cycle strobe, equal to OR of (rise_o | fall_o).
- evt_o  out  WIDTH  sticky per-bit change flags.
- clr_i  in  WIDTH  per-bit write-one-to-clear for evt_o.

Behaviour:
- Reset:
  - Applied asynchronously whenever arst_n_i is low; released synchronously at the next clk_i edge with arst_n_i high.
  - During reset: sync chain = RESET_VAL, data_o = RESET_VAL, all counters = 0, rise_o = fall_o = 0, chg_o = 0, evt_o = 0.
  - Reset mid-debounce discards any partial count. No strobe is emitted for the reset itself.
- Synchronizer:
  - raw_i[i] passes through SYNC_STAGES flops; s[i] is the last stage.
  - No logic sits between stages.
- Per-bit counter cnt[i] (all bits independent; simultaneous activity on different bits is legal):
  - If s[i] == data_o[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: data_o[i] <= s[i], cnt[i] <= 0, and a strobe fires in the same cycle that data_o updates (rise_o[i] if s[i]==1, otherwise fall_o[i]).
  - Else: cnt[i] <= cnt[i]+1.
  - Strobes are registered and high for exactly one cycle.
- Latency:
  - A clean input step first sampled at edge 0 appears on data_o after edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - rise_o/fall_o are asserted in that same cycle.
  - DEBOUNCE_CYCLES=1 degenerates to synchronizer-only with one extra register stage.
- Glitch rejection: any sampled s[i] that returns to data_o[i] before the count completes restarts the count from 0. data_o never toggles on pulses shorter than DEBOUNCE_CYCLES synchronized cycles.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- evt_o[i]:
  - Set on the cycle rise_o[i] or fall_o[i] is high.
  - Cleared when clr_i[i]=1.
  - Set and clear in the same cycle: set wins, evt_o[i] stays 1.
  - clr_i on an already-clear bit has no effect.
- chg_o is combinational from the registered strobes: chg_o = |(rise_o|fall_o).
- No path exists from raw_i to any output except through the synchronizer.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=16, RESET_VAL=0 unless stated):
- Reset check: hold arst_n_i=0 with raw_i=16'hFFFF -> data_o, rise_o, fall_o, evt_o all 0, chg_o=0. After release, data_o=16'hFFFF at edge 5, rise_o=16'hFFFF for exactly that one cycle, and evt_o=16'hFFFF from edge 6.
- Clean step: raw_i[3] 0->1, first sampled at edge 0 -> data_o[3]=1 and rise_o[3]=1 after edge 5; rise_o[3]=0 after edge 6; chg_o=1 only in that cycle; evt_o[3]=1 from edge 6.
- Glitch: raw_i[0] high for 3 cycles, then low -> data_o[0], rise_o[0] and evt_o[0] all remain 0. Then high for 4 cycles -> data_o[0]=1.
- Simultaneous: raw_i[15:8] 0->1 and raw_i[7:0] steady 1 falling to 0 on the same edge -> rise_o=16'hFF00 and fall_o=16'h00FF in the same single cycle, chg_o=1.
- Sticky clear race: evt_o[5]=1, then clr_i[5]=1 on the cycle a new fall_o[5] fires -> evt_o[5] stays 1. The following clr_i[5]=1 with no event -> evt_o[5]=0.
- Reset mid-count: raw_i[2]=1 held 2 cycles into debounce, pulse arst_n_i low for 1 cycle -> no rise_o[2], count restarts. data_o[2]=1 only after a full SYNC_STAGES+DEBOUNCE_CYCLES from release.

Source files
------------

// File: rtl/gpio_in_debounce.sv
// Switch input conditioning: per-bit synchronizer, stability counter, edge strobes
// and sticky write-one-to-clear change flags for the GPIO input bus.
module gpio_in_debounce #(
   parameter int unsigned       WIDTH           = 16,
   parameter int unsigned       SYNC_STAGES     = 2,
   parameter int unsigned       DEBOUNCE_CYCLES = 250000,
   parameter logic [WIDTH-1:0]  RESET_VAL       = '0
) (
   input  logic             clk_i,
   input  logic             arst_n_i,
   input  logic [WIDTH-1:0] raw_i,
   input  logic [WIDTH-1:0] clr_i,
   output logic [WIDTH-1:0] data_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             chg_o,
   output logic [WIDTH-1:0] evt_o
);

   localparam int unsigned      SyncN  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int unsigned      CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SyncN];
   logic [WIDTH-1:0] sync_s;

   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] evt_q, evt_d;

   // Plain flop chain; nothing may sit between stages.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int i = 0; i < SyncN; i++) begin
            sync_q[i] <= RESET_VAL;
         end
      end else begin
         sync_q[0] <= raw_i;
         for (int i = 1; i < SyncN; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_s = sync_q[SyncN-1];

   always_comb begin
      data_d = data_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_s[i] != data_q[i]) begin
            // Final qualifying cycle: accept the new level and strobe in the same edge.
            if (cnt_q[i] == CntMax) begin
               data_d[i] = sync_s[i];
               rise_d[i] = sync_s[i];
               fall_d[i] = ~sync_s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      // Set takes priority over a coincident clear.
      evt_d = (evt_q & ~clr_i) | rise_q | fall_q;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         data_q <= RESET_VAL;
         rise_q <= '0;
         fall_q <= '0;
         evt_q  <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         data_q <= data_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         evt_q  <= evt_d;
      end
   end

   assign data_o = data_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
   assign evt_o  = evt_q;
   assign chg_o  = |(rise_q | fall_q);

endmodule
